// File: rtl/intc_arbiter.sv
// rtl/intc_arbiter.sv - MMIO interrupt controller/arbiter feeding cp0; optional INTC_ROUND_ROBIN_EN
module intc_arbiter #(
    parameter int unsigned NUM_SRC   = 4,
    parameter logic [31:0] BASE_ADDR = 32'hffff0080
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [31:0]        address,
    input  logic [31:0]        wr_data,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               taken_interrupt,
    output logic               intc_interrupt,
    output logic               intc_address,
    output logic [31:0]        rd_data
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] pending_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] irq_prev_q;
    logic [2:0]         svc_id_q;
    logic               in_svc_q;
`ifdef INTC_ROUND_ROBIN_EN
    logic [2:0]         rr_ptr_q;
`endif

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] win_oh;
    logic [2:0]         winner;
    logic [1:0]         off;
    logic               wr_en;
    logic               mask_wr;
    logic               ack_wr;
    logic               eoi_wr;
    logic               take;
    logic               unused_bits;

    assign off          = address[3:2];
    assign intc_address = (address[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);
    assign wr_en        = intc_address && MemWrite;
    assign mask_wr      = wr_en && (off == 2'd1);
    assign ack_wr       = wr_en && (off == 2'd2);
    assign eoi_wr       = wr_en && (off == 2'd3);
    assign rise         = irq_src & ~irq_prev_q;
    assign req          = pending_q & mask_q;
    assign take         = (state_q == S_REQ) && taken_interrupt;
    assign intc_interrupt = (state_q == S_REQ);
    assign unused_bits  = ^{address[1:0], wr_data};

    // Pick the winning source: lowest requesting index, or with round-robin the
    // lowest index at/after rr_ptr, falling back to the lowest overall (wrap).
    always_comb begin
        winner = 3'd0;
        win_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner    = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
`ifdef INTC_ROUND_ROBIN_EN
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(rr_ptr_q))) begin
                winner    = 3'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
`endif
    end

    // Next pending: ACK clears, service entry clears the winner, a new edge always wins.
    always_comb begin
        pending_d = pending_q;
        if (ack_wr) begin
            pending_d = pending_d & ~wr_data[NUM_SRC-1:0];
        end
        if (take) begin
            pending_d = pending_d & ~win_oh;
        end
        pending_d = pending_d | rise;
    end

    // Register read mux; zero unless this is a load hitting the window.
    always_comb begin
        rd_data = 32'd0;
        if (intc_address && MemRead) begin
            case (off)
                2'd0:    rd_data = 32'(pending_q);
                2'd1:    rd_data = 32'(mask_q);
                2'd2:    rd_data = 32'd0;
                default: rd_data = {in_svc_q, 28'd0, svc_id_q};
            endcase
        end
    end

    // Edge history, pending and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
        end else begin
            irq_prev_q <= irq_src;
            pending_q  <= pending_d;
            if (mask_wr) begin
                mask_q <= wr_data[NUM_SRC-1:0];
            end
        end
    end

    // Service sequencer: request cp0, latch the winner on take, hold until EOI.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            svc_id_q <= 3'd0;
            in_svc_q <= 1'b0;
`ifdef INTC_ROUND_ROBIN_EN
            rr_ptr_q <= 3'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (taken_interrupt) begin
                        state_q  <= S_SERVICE;
                        svc_id_q <= winner;
                        in_svc_q <= 1'b1;
`ifdef INTC_ROUND_ROBIN_EN
                        rr_ptr_q <= (winner == 3'(NUM_SRC - 1)) ? 3'd0 : winner + 3'd1;
`endif
                    end else if (!(|req)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    if (eoi_wr) begin
                        state_q  <= S_IDLE;
                        in_svc_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
